// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store port between execute and data memory.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_valid / o_ready              op handshake from execute (ready only when idle)
//   i_load, i_store, i_funct3      op kind and RV32I width code
//   i_addr, i_wdata                effective byte address, store data
//   i_rd_addr, i_rd_en, i_tid      load destination and issuing thread
//   o_mem_*                        word-aligned request with byte enables and lane data
//   i_mem_gnt, i_mem_rvalid/rdata  grant and read response
//   o_wb_*                         load result to writeback (one-cycle pulse)
//   o_err_*                        misaligned / illegal op report (one-cycle pulse)
module lsu_mem_port #(
   parameter int XLEN     = 32,
   parameter int ADDR_LEN = 32,
   parameter int TID_W    = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic                i_load,
   input  logic                i_store,
   input  logic [2:0]          i_funct3,
   input  logic [ADDR_LEN-1:0] i_addr,
   input  logic [XLEN-1:0]     i_wdata,
   input  logic [4:0]          i_rd_addr,
   input  logic                i_rd_en,
   input  logic [TID_W-1:0]    i_tid,
   output logic                o_mem_req,
   output logic                o_mem_we,
   output logic [ADDR_LEN-1:0] o_mem_addr,
   output logic [3:0]          o_mem_be,
   output logic [XLEN-1:0]     o_mem_wdata,
   input  logic                i_mem_gnt,
   input  logic                i_mem_rvalid,
   input  logic [XLEN-1:0]     i_mem_rdata,
   output logic                o_wb_valid,
   output logic                o_wb_rd_en,
   output logic [4:0]          o_wb_rd_addr,
   output logic [TID_W-1:0]    o_wb_tid,
   output logic [XLEN-1:0]     o_wb_data,
   output logic                o_err_valid,
   output logic [TID_W-1:0]    o_err_tid,
   output logic [ADDR_LEN-1:0] o_err_addr
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   state_t r_state, w_next;
   logic                w_accept, w_ld_ok, w_st_ok, w_err, w_misal, w_resp;
   logic [3:0]          w_be;
   logic [XLEN-1:0]     w_wdata, w_ldata;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic                r_we, r_rd_en, r_wb_valid, r_err_valid;
   logic [3:0]          r_be;
   logic [2:0]          r_funct3;
   logic [4:0]          r_rd_addr;
   logic [TID_W-1:0]    r_tid;
   logic [ADDR_LEN-1:0] r_addr, r_mem_addr;
   logic [XLEN-1:0]     r_mem_wdata, r_wb_data;

   assign o_ready  = (r_state == IDLE);
   assign w_accept = i_valid && o_ready;
   assign w_resp   = (r_state == WAIT) && i_mem_rvalid;
   assign w_ld_ok  = i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   assign w_st_ok  = i_funct3 inside {3'b000, 3'b001, 3'b010};
   assign w_misal  = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                     (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
   assign w_err    = (i_load == i_store) || !(i_load ? w_ld_ok : w_st_ok) || w_misal;
   assign w_be     = i_funct3[1:0] == 2'b00 ? 4'b0001 << i_addr[1:0] :
                     i_funct3[1:0] == 2'b01 ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   // Narrow stores are replicated across lanes so the byte enables alone pick the target.
   assign w_wdata  = i_funct3[1:0] == 2'b00 ? {4{i_wdata[7:0]}} :
                     i_funct3[1:0] == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
   // Lane selection uses the byte offset captured at accept, not the aligned request address.
   assign w_half   = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
   assign w_byte   = r_addr[0] ? w_half[15:8] : w_half[7:0];
   assign w_ldata  = r_funct3 == 3'b000 ? {{(XLEN-8){w_byte[7]}}, w_byte} :
                     r_funct3 == 3'b001 ? {{(XLEN-16){w_half[15]}}, w_half} :
                     r_funct3 == 3'b100 ? {{(XLEN-8){1'b0}}, w_byte} :
                     r_funct3 == 3'b101 ? {{(XLEN-16){1'b0}}, w_half} : i_mem_rdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept && !w_err) w_next = REQ;
         REQ:     if (i_mem_gnt) w_next = r_we ? IDLE : WAIT;
         WAIT:    if (i_mem_rvalid) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_we        <= 1'b0;
         r_be        <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_funct3    <= '0;
         r_addr      <= '0;
         r_tid       <= '0;
         r_rd_addr   <= '0;
         r_rd_en     <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_wb_data   <= '0;
         r_err_valid <= 1'b0;
      end else begin
         r_wb_valid  <= w_resp;
         r_err_valid <= w_accept && w_err;
         if (w_accept) begin
            r_funct3  <= i_funct3;
            r_addr    <= i_addr;
            r_tid     <= i_tid;
            r_rd_addr <= i_rd_addr;
            r_rd_en   <= i_rd_en;
         end
         if (w_accept && !w_err) begin
            r_we        <= i_store;
            r_be        <= w_be;
            r_mem_addr  <= {i_addr[ADDR_LEN-1:2], 2'b00};
            r_mem_wdata <= w_wdata;
         end
         if (w_resp) r_wb_data <= w_ldata;
      end
   end

   assign o_mem_req    = (r_state == REQ);
   assign o_mem_we     = r_we;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_be     = r_be;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_wb_valid   = r_wb_valid;
   // Writes to x0 still access memory but never reach the register file.
   assign o_wb_rd_en   = r_rd_en && (r_rd_addr != 5'd0);
   assign o_wb_rd_addr = r_rd_addr;
   assign o_wb_tid     = r_tid;
   assign o_wb_data    = r_wb_data;
   assign o_err_valid  = r_err_valid;
   assign o_err_tid    = r_tid;
   assign o_err_addr   = r_addr;
endmodule
